// File: rtl/hs_npu_pkg.sv
// Shared types and defaults for the NPU systolic-array scheduler slice.
package hs_npu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN
  } sched_state_e;

  localparam int NPU_DATA_W = 16;
  localparam int NPU_ACC_W  = 32;

  // Input skew plus output de-skew latency for an n x n array.
  function automatic int sched_lat(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/hs_npu_skew_line.sv
// Per-lane register delay line; lane i delays BASE+i, or BASE+(L-1-i) when REVERSE.
module hs_npu_skew_line #(
  parameter int L       = 4,
  parameter int W       = 16,
  parameter int BASE    = 0,
  parameter bit REVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [L*W-1:0] din,
  output logic [L*W-1:0] dout
);

  for (genvar i = 0; i < L; i++) begin : g_lane
    localparam int unsigned D = $unsigned(BASE + (REVERSE ? (L - 1 - i) : i));

    if (D == 0) begin : g_pass
      assign dout[i*W +: W] = din[i*W +: W];
    end else begin : g_dly
      logic [W-1:0] sr [D];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < D; k++) sr[k] <= '0;
        end else begin
          sr[0] <= din[i*W +: W];
          for (int unsigned k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
      end

      assign dout[i*W +: W] = sr[D-1];
    end
  end

endmodule

// File: rtl/hs_npu_array_sched.sv
// Weight-stationary systolic array sequencer: weight load, skewed activation
// streaming and de-skew of the bottom-row partial sums into result vectors.
module hs_npu_array_sched
  import hs_npu_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = NPU_DATA_W,
  parameter int ACC_W  = NPU_ACC_W,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                reuse_w_i,
  input  logic [CNT_W-1:0]    num_vec_i,
  output logic                busy_o,
  output logic                done_o,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [N*DATA_W-1:0] w_data_i,
  input  logic                x_valid_i,
  output logic                x_ready_o,
  input  logic [N*DATA_W-1:0] x_data_i,
  output logic                arr_w_en_o,
  output logic [N*DATA_W-1:0] arr_b_o,
  output logic [N*DATA_W-1:0] arr_a_o,
  input  logic [N*ACC_W-1:0]  arr_sum_i,
  output logic                res_valid_o,
  output logic [N*ACC_W-1:0]  res_data_o
);

  localparam int LAT  = sched_lat(N);
  localparam int WC_W = $clog2(N + 1);
  localparam int DC_W = $clog2(LAT + 1);

  sched_state_e        state, nstate;
  logic                w_resident;
  logic [WC_W-1:0]     wcnt;
  logic [CNT_W-1:0]    vcnt, num_vec_q;
  logic [DC_W-1:0]     dcnt;
  logic [LAT-1:0]      vpipe;
  logic                w_hs, x_hs, w_last, x_last, d_last, load_job;
  logic [N*DATA_W-1:0] skew_in;
  logic [N*ACC_W-1:0]  deskew_out;

  assign w_hs     = w_ready_o & w_valid_i;
  assign x_hs     = x_ready_o & x_valid_i;
  assign w_last   = (wcnt == WC_W'(N - 1));
  assign x_last   = (vcnt == num_vec_q - CNT_W'(1));
  assign d_last   = (dcnt == DC_W'(LAT - 1));
  assign load_job = !reuse_w_i || !w_resident;

  always_comb begin
    nstate    = state;
    w_ready_o = 1'b0;
    x_ready_o = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (load_job)               nstate = LOAD;
          else if (num_vec_i == '0)   nstate = DRAIN;
          else                        nstate = STREAM;
        end
      end
      LOAD: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last) nstate = (num_vec_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        x_ready_o = 1'b1;
        if (x_valid_i && x_last) nstate = DRAIN;
      end
      DRAIN: begin
        if (d_last) begin
          done_o = 1'b1;
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  assign busy_o      = (state != IDLE);
  assign arr_w_en_o  = w_hs;
  assign arr_b_o     = w_hs ? w_data_i : '0;
  assign skew_in     = x_hs ? x_data_i : '0;
  assign res_valid_o = vpipe[LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      w_resident <= 1'b0;
      wcnt       <= '0;
      vcnt       <= '0;
      dcnt       <= '0;
      num_vec_q  <= '0;
      vpipe      <= '0;
      res_data_o <= '0;
    end else begin
      state <= nstate;
      vpipe <= {vpipe[LAT-2:0], x_hs};
      if (state == IDLE && start_i) begin
        num_vec_q <= num_vec_i;
        // A fresh load invalidates residency until its last row lands.
        if (load_job) w_resident <= 1'b0;
      end
      if (w_hs && w_last) w_resident <= 1'b1;
      wcnt <= (state == LOAD)   ? (w_hs ? wcnt + WC_W'(1) : wcnt)  : '0;
      vcnt <= (state == STREAM) ? (x_hs ? vcnt + CNT_W'(1) : vcnt) : '0;
      dcnt <= (state == DRAIN)  ? dcnt + DC_W'(1) : '0;
      if (vpipe[LAT-2]) res_data_o <= deskew_out;
    end
  end

  hs_npu_skew_line #(
    .L(N), .W(DATA_W), .BASE(1), .REVERSE(1'b0)
  ) u_skew (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (skew_in),
    .dout (arr_a_o)
  );

  hs_npu_skew_line #(
    .L(N), .W(ACC_W), .BASE(0), .REVERSE(1'b1)
  ) u_deskew (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (arr_sum_i),
    .dout (deskew_out)
  );

endmodule
